// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl: single-opcode command parser sitting between the UART RX/TX byte streams
// and the LED port. Owns the LED register; answers every command with one response byte.
// Optional blink feature (blink mask, free-running blink counter, 'B' opcode) is built only
// when UART_LED_BLINK_EN is defined.
module uart_led_cmd_ctrl #(
  parameter int unsigned LED_W     = 7,
  parameter logic [23:0] BLINK_DIV = 24'd10_000_000,
  parameter logic [15:0] TIMEOUT   = 16'd50_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [LED_W-1:0] led_port,
  output logic             busy,
  output logic             err
);

  localparam logic [7:0] OpSet   = 8'h53;  // 'S'
  localparam logic [7:0] OpRead  = 8'h52;  // 'R'
  localparam logic [7:0] RespOk  = 8'h4B;  // 'K'
  localparam logic [7:0] RespBad = 8'h3F;  // '?'
`ifdef UART_LED_BLINK_EN
  localparam logic [7:0] OpBlink = 8'h42;  // 'B'
`endif

  typedef enum logic [1:0] {StIdle, StArg, StResp} state_e;

  state_e            state_q;
  logic [LED_W-1:0]  led_reg_q;
  logic [15:0]       timeout_cnt_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              err_q;
  logic [7:0]        led_ext;
`ifdef UART_LED_BLINK_EN
  logic              op_blink_q;
  logic [LED_W-1:0]  blink_mask_q;
  logic [23:0]       blink_cnt_q;
  logic              phase_q;
`endif

  // Read-back response is the LED register zero-extended to a byte.
  assign led_ext = 8'(led_reg_q);

  // Command FSM: state, argument timeout, LED/blink registers and registered TX/err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      led_reg_q     <= '0;
      timeout_cnt_q <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      err_q         <= 1'b0;
`ifdef UART_LED_BLINK_EN
      op_blink_q    <= 1'b0;
      blink_mask_q  <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == OpSet) begin
              state_q       <= StArg;
              timeout_cnt_q <= '0;
`ifdef UART_LED_BLINK_EN
              op_blink_q    <= 1'b0;
            end else if (rx_data == OpBlink) begin
              state_q       <= StArg;
              timeout_cnt_q <= '0;
              op_blink_q    <= 1'b1;
`endif
            end else if (rx_data == OpRead) begin
              state_q    <= StResp;
              tx_valid_q <= 1'b1;
              tx_data_q  <= led_ext;
            end else begin
              state_q    <= StResp;
              tx_valid_q <= 1'b1;
              tx_data_q  <= RespBad;
              err_q      <= 1'b1;
            end
          end
        end
        StArg: begin
          // An argument arriving on the timeout cycle still wins.
          if (rx_valid) begin
`ifdef UART_LED_BLINK_EN
            if (op_blink_q) blink_mask_q <= rx_data[LED_W-1:0];
            else            led_reg_q    <= rx_data[LED_W-1:0];
`else
            led_reg_q <= rx_data[LED_W-1:0];
`endif
            state_q    <= StResp;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RespOk;
          end else if (timeout_cnt_q == TIMEOUT - 16'd1) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 16'd1;
          end
        end
        StResp: begin
          // Bytes arriving while a response is pending are dropped and flagged.
          if (rx_valid) err_q <= 1'b1;
          if (tx_ready) begin
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UART_LED_BLINK_EN
  // Free-running blink divider; phase flips each time the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_DIV - 24'd1) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 24'd1;
    end
  end

  assign led_port = led_reg_q ^ (blink_mask_q & {LED_W{phase_q}});
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign led_port = led_reg_q;
`endif

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;
  assign busy     = (state_q != StIdle);

endmodule
